// File: rtl/t05_header_serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : t05_header_serializer_p
// Purpose  : Queues Huffman header requests and serialises each one as a
//            marker bit, the character index and 0-2 trailing zeros.
// Revision : 1.0  initial release
// ============================================================================
module t05_header_serializer_p #(
    parameter int CHAR_W    = 8,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [CHAR_W-1:0]      char_index,
    input  logic [CHAR_W:0]        least1,
    input  logic [CHAR_W:0]        least2,
    input  logic                   abort,
    output logic                   bit_out,
    output logic                   bit_valid,
    input  logic                   bit_ready,
    output logic                   write_finish,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(CHAR_W + 4);
    localparam int c_ENT_W = CHAR_W + 2;
    localparam logic [c_PTR_W:0] c_FULL = DEPTH[c_PTR_W:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_ready_en;

    state_t             r_state;
    logic [CHAR_W-1:0]  r_shift;
    logic [1:0]         r_zeros;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_zeros;
    logic [c_ENT_W-1:0] w_head;
    logic [c_CNT_W-1:0] w_last_cnt;
    logic               w_idx_bit;
    logic [CHAR_W-1:0]  w_shift_nxt;
    logic               w_unused_least1;

    // The leaf index of least1 never affects the header, only its sum flag.
    assign w_unused_least1 = ^least1[CHAR_W-1:0];

    assign w_full     = (r_count == c_FULL);
    assign req_ready  = r_ready_en && !w_full && !abort;
    assign w_push     = req_valid && req_ready;
    assign w_pop      = (r_state == ST_IDLE) && (r_count != '0) && !abort;
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign w_last_cnt = c_CNT_W'(CHAR_W) + c_CNT_W'(r_zeros);

    always_comb begin
        w_zeros = 2'd0;
        if (!least1[CHAR_W] && !least2[CHAR_W] && (char_index == least2[CHAR_W-1:0])) begin
            w_zeros = 2'd2;
        end else if (least1[CHAR_W] ^ least2[CHAR_W]) begin
            w_zeros = 2'd1;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_idx_bit   = r_shift[CHAR_W-1];
            assign w_shift_nxt = r_shift << 1;
        end else begin : g_lsb_first
            assign w_idx_bit   = r_shift[0];
            assign w_shift_nxt = r_shift >> 1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_zeros, char_index};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_zeros      <= 2'd0;
            r_cnt        <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            write_finish <= 1'b0;
            busy         <= 1'b0;
        end else begin
            write_finish <= 1'b0;
            if (abort) begin
                r_state   <= ST_IDLE;
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_shift   <= w_head[CHAR_W-1:0];
                            r_zeros   <= w_head[CHAR_W+1:CHAR_W];
                            r_cnt     <= '0;
                            r_state   <= ST_SEND;
                            bit_out   <= 1'b1;
                            bit_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (bit_ready) begin
                            if (r_cnt == w_last_cnt) begin
                                r_state      <= ST_IDLE;
                                bit_out      <= 1'b0;
                                bit_valid    <= 1'b0;
                                busy         <= 1'b0;
                                write_finish <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                                // Next count is an index bit while still inside the character field.
                                if (r_cnt < c_CNT_W'(CHAR_W)) begin
                                    bit_out <= w_idx_bit;
                                    r_shift <= w_shift_nxt;
                                end else begin
                                    bit_out <= 1'b0;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t05_header_serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_header_serializer_p
// Purpose  : Randomised scoreboard bench for the header serialiser.
// Revision : 1.0  initial release
// ============================================================================
module tb_t05_header_serializer_p;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] char_index = '0;
    logic [8:0] least1 = '0;
    logic [8:0] least2 = '0;
    logic       abort = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready = 1'b0;
    logic       write_finish;
    logic       busy;
    logic [1:0] fifo_count;

    logic       req_valid4 = 1'b0;
    logic       req_ready4;
    logic [3:0] char4 = '0;
    logic [4:0] l1_4 = '0;
    logic [4:0] l2_4 = '0;
    logic       bit_out4;
    logic       bit_valid4;
    logic       wf4;
    logic       busy4;
    logic [1:0] fc4;

    int  n_vec = 0;
    int  n_err = 0;
    int  rdy_mode = 0;
    bit  tog = 1'b0;
    bit  flush_req = 1'b0;
    bit  mdl_q[$];
    bit  exp_bits[$];
    int  exp_len[$];
    int  hdr_bits = 0;
    bit  prev_stall = 1'b0;
    bit  prev_bit = 1'b0;

    always #5 clk = ~clk;

    t05_header_serializer_p #(.CHAR_W(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .char_index(char_index), .least1(least1), .least2(least2), .abort(abort),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .write_finish(write_finish), .busy(busy), .fifo_count(fifo_count)
    );

    t05_header_serializer_p #(.CHAR_W(4), .DEPTH(2), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid4), .req_ready(req_ready4),
        .char_index(char4), .least1(l1_4), .least2(l2_4), .abort(1'b0),
        .bit_out(bit_out4), .bit_valid(bit_valid4), .bit_ready(1'b1),
        .write_finish(wf4), .busy(busy4), .fifo_count(fc4)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endfunction

    // Reference header: marker, index bits in the chosen order, then zeros by node type.
    function automatic void model(input int cw, input bit msb, input int c, input int l1, input int l2);
        bit s1;
        bit s2;
        int z;
        s1 = ((l1 >> cw) & 1) != 0;
        s2 = ((l2 >> cw) & 1) != 0;
        if (!s1 && !s2 && (c == (l2 & ((1 << cw) - 1)))) z = 2;
        else if (s1 != s2) z = 1;
        else z = 0;
        mdl_q.delete();
        mdl_q.push_back(1'b1);
        for (int i = 0; i < cw; i++) begin
            mdl_q.push_back(msb ? (((c >> (cw - 1 - i)) & 1) != 0) : (((c >> i) & 1) != 0));
        end
        for (int i = 0; i < z; i++) mdl_q.push_back(1'b0);
    endfunction

    always @(posedge clk) begin
        #2;
        tog = ~tog;
        case (rdy_mode)
            0:       bit_ready = 1'b0;
            1:       bit_ready = 1'b1;
            2:       bit_ready = tog;
            default: bit_ready = ($urandom % 4) != 0;
        endcase
    end

    // Scoreboard monitor: pops one expected bit per handshake and one length per write_finish.
    always @(negedge clk) begin
        if (flush_req) begin
            exp_bits.delete();
            exp_len.delete();
            hdr_bits = 0;
            flush_req = 1'b0;
        end
        if (nrst) begin
            if (!bit_valid) check("idle_bit_zero", bit_out, 0);
            if (prev_stall) begin
                check("hold_valid", bit_valid, 1);
                check("hold_bit", bit_out, prev_bit);
            end
            if (bit_valid && bit_ready) begin
                if (exp_bits.size() == 0) fail_now("unexpected_bit");
                else check("stream_bit", bit_out, exp_bits.pop_front());
                hdr_bits++;
            end
            if (write_finish) begin
                if (exp_len.size() == 0) fail_now("unexpected_finish");
                else check("header_len", hdr_bits, exp_len.pop_front());
                hdr_bits = 0;
            end
            prev_stall = bit_valid && !bit_ready && !abort;
            prev_bit   = bit_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_req(input logic [7:0] c, input logic [8:0] a, input logic [8:0] b);
        int t = 0;
        req_valid = 1'b1; char_index = c; least1 = a; least2 = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 500) begin
                fail_now("req_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        if (t <= 500) begin
            model(8, 1'b1, int'(c), int'(a), int'(b));
            foreach (mdl_q[i]) exp_bits.push_back(mdl_q[i]);
            exp_len.push_back(mdl_q.size());
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_len.size() != 0 || bit_valid || fifo_count != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) fail_now("idle_timeout");
    endtask

    task automatic run_variant(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b);
        bit got[$];
        int t = 0;
        model(4, 1'b0, int'(c), int'(a), int'(b));
        req_valid4 = 1'b1; char4 = c; l1_4 = a; l2_4 = b;
        @(negedge clk);
        check("v_req_ready", req_ready4, 1);
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        while (t < 40) begin
            @(negedge clk);
            t++;
            if (bit_valid4) got.push_back(bit_out4);
            if (wf4) break;
        end
        check("v_finish", wf4, 1);
        check("v_len", got.size(), mdl_q.size());
        for (int i = 0; i < got.size() && i < mdl_q.size(); i++) check("v_bit", got[i], mdl_q[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int nv;
        int nz;
        int nwf;
        logic [7:0] rc;
        logic [8:0] ra;
        logic [8:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_finish", write_finish, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_v_valid", bit_valid4, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);
        @(posedge clk); #1;

        run_variant(4'hA, 5'h10, 5'h0A);
        for (int i = 0; i < 6; i++) begin
            rc = 8'($urandom);
            run_variant(rc[3:0], 5'($urandom), (i % 2 == 0) ? {1'b0, rc[3:0]} : 5'($urandom));
        end

        rdy_mode = 1;
        send_req(8'h41, 9'h005, 9'h041);
        @(negedge clk);
        check("lat_not_yet_valid", bit_valid, 0);
        check("lat_count_one", fifo_count, 1);
        @(negedge clk);
        check("lat_first_valid", bit_valid, 1);
        check("lat_marker", bit_out, 1);
        check("lat_popped", fifo_count, 0);
        check("lat_busy", busy, 1);
        wait_idle();

        rdy_mode = 2;
        send_req(8'h03, 9'h1FF, 9'h003);
        wait_idle();

        rdy_mode = 0;
        send_req(8'h41, 9'h005, 9'h041);
        send_req(8'h03, 9'h1FF, 9'h003);
        send_req(8'h7E, 9'h100, 9'h101);
        @(negedge clk);
        check("full_count", fifo_count, 2);
        check("full_ready", req_ready, 0);
        check("full_busy", busy, 1);
        check("full_marker_held", bit_out, 1);
        @(posedge clk); #1;
        rdy_mode = 1;
        nv = 0; nz = 0; nwf = 0; t = 0;
        while (nwf < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (write_finish) nwf++;
            if (nwf < 3) begin
                if (bit_valid) nv++;
                else nz++;
            end
        end
        check("full_finishes", nwf, 3);
        check("full_valid_cycles", nv, 30);
        check("full_gap_cycles", nz, 2);
        wait_idle();

        send_req(8'h5A, 9'h0A5, 9'h05A);
        send_req(8'h11, 9'h100, 9'h022);
        t = 0;
        while (hdr_bits < 4 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_queued", fifo_count, 1);
        abort = 1'b1; rdy_mode = 0; flush_req = 1'b1;
        req_valid = 1'b1; char_index = 8'h22; least1 = 9'h100; least2 = 9'h100;
        @(negedge clk);
        check("abort_no_ready", req_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("abort_valid", bit_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_finish", write_finish, 0);
        rdy_mode = 1;
        repeat (5) begin @(posedge clk); #1; end
        send_req(8'hC3, 9'h0C3, 9'h0C3);
        wait_idle();

        send_req(8'h99, 9'h1AA, 9'h1BB);
        t = 0;
        while (hdr_bits < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        #2;
        nrst = 1'b0; flush_req = 1'b1;
        #1;
        check("arst_valid", bit_valid, 0);
        check("arst_bit", bit_out, 0);
        check("arst_busy", busy, 0);
        check("arst_finish", write_finish, 0);
        check("arst_count", fifo_count, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        rdy_mode = 3;
        for (int i = 0; i < 40; i++) begin
            rc = 8'($urandom);
            ra = 9'($urandom);
            case ($urandom % 3)
                0:       begin ra[8] = 1'b0; rb = {1'b0, rc}; end
                1:       rb = 9'($urandom);
                default: begin rb = 9'($urandom); rb[8] = ~ra[8]; end
            endcase
            send_req(rc, ra, rb);
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t05_header_serializer_p.md
Name: t05_header_serializer_p

Overview:
- Parametrised successor to the team's Huffman header synthesis stage.
- Accepts header requests (char index plus the two least-frequency nodes) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each header as a marker '1', CHAR_W index bits, then 0–2 trailing zeros, over a bit-stream valid/ready interface with backpressure.
- Sits between the tree-building/backtrack logic and the header writer.

Parameters:
- CHAR_W, 8: width of the character index; node width is CHAR_W+1, MSB = sum flag.
- DEPTH, 2: request FIFO depth; power of two, ≥2.
- MSB_FIRST, 1: 1 sends index bits MSB first, 0 sends LSB first. Marker and zeros are unaffected.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  header request present
- req_ready  out  1  FIFO can accept a request
- char_index  in  CHAR_W  character for this header
- least1  in  CHAR_W+1  first least node; [CHAR_W]=1 means sum node
- least2  in  CHAR_W+1  second least node; same encoding
- abort  in  1  synchronous flush of FIFO and serialiser
- bit_out  out  1  serial header bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  consumer accepts bit_out
- write_finish  out  1  one-cycle pulse: header fully sent
- busy  out  1  serialiser in SEND state
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (nrst low, async):
  - FIFO empty, state IDLE.
  - bit_out=0, bit_valid=0, write_finish=0, busy=0, fifo_count=0.
  - req_ready=1 from the first edge after release.
- Enqueue on clk edge with req_valid && req_ready. req_ready = !full && !abort; there is no bypass when full.
- Zero count is computed at enqueue and stored with the char in each {zeros[1:0], char} entry:
  - 2 if least1[CHAR_W]==0 && least2[CHAR_W]==0 && char_index==least2[CHAR_W-1:0].
  - Else 1 if exactly one of least1[CHAR_W], least2[CHAR_W] is 1.
  - Else 0.
- Header length L = 1+CHAR_W+zeros. Bit counter width is $clog2(CHAR_W+4).
- FSM states: IDLE, SEND.
  - IDLE: if FIFO non-empty and !abort, pop the head entry, load the shift register, clear the counter, go to SEND.
  - SEND:
    - bit_valid=1, busy=1. bit_out = marker at count 0, index bits at counts 1..CHAR_W (order per MSB_FIRST), 0 at counts >CHAR_W.
    - On bit_valid && bit_ready, the counter increments.
    - On the handshake where count==L-1, go to IDLE and register write_finish=1 for exactly the next cycle.
    - bit_out and the counter hold while bit_ready=0.
- Latency:
  - A request accepted at edge N into an empty FIFO in IDLE is popped at edge N+1.
  - Its first bit is valid after edge N+1.
  - Exactly one idle cycle separates consecutive headers; that cycle is the write_finish cycle, in which IDLE may pop the next entry.
- Simultaneous push and pop in the same cycle is allowed; fifo_count stays unchanged.
- FIFO pointers wrap modulo DEPTH.
- bit_out=0 whenever bit_valid=0.
- abort (sampled at clk):
  - Next edge empties the FIFO and returns the FSM to IDLE.
  - Clears bit_valid/busy; no write_finish for the dropped header.
  - A concurrent request is not accepted (req_ready=0 during abort).
- nrst asserted mid-header discards everything immediately, asynchronously.

Test Plan:
- Single request: char_index=0x41, least1=0x005, least2=0x041, bit_ready=1.
  - Bits 1,0,1,0,0,0,0,0,1,0,0 (11 bits, zeros=2) on 11 consecutive cycles.
  - write_finish pulses once on the next cycle; fifo_count returns to 0.
- Backpressure: char_index=0x03, least1=0x1FF (sum), least2=0x003, bit_ready toggling 1,0,1,0.
  - 10 bits 1,0,0,0,0,0,0,1,1,0; each bit held stable while bit_ready=0.
  - Exactly 10 handshakes, then write_finish.
- FIFO full: 3 back-to-back requests with DEPTH=2 while bit_ready=0.
  - Entry 1 is popped into SEND, entries 2–3 fill the FIFO (fifo_count=2) and req_ready drops.
  - Releasing bit_ready yields headers in order, separated by one-cycle gaps with write_finish pulses.
- Both sum nodes: least1=0x100, least2=0x101, char_index=0x7E → 9 bits, zeros=0.
- abort mid-header: abort after 4 bits sent with 1 entry queued.
  - Next cycle bit_valid=0, fifo_count=0, no write_finish.
  - A new request afterwards starts a clean header with the marker bit.
- Parameter variant CHAR_W=4, MSB_FIRST=0: char_index=0xA, least1=0x10 (sum), least2=0x0A → bits 1,0,1,0,1,0 (zeros=1).
- Async reset asserted mid-SEND → all outputs 0 immediately, without waiting for a clock edge.
